// File: rtl/chg_pkg.sv
// ============================================================================
// Module      : chg_pkg
// Description : Shared types and constants for the change-frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ID   = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_ACK  = 3'd5
    } state_e;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

    // Sync + index + data bytes + checksum.
    function automatic int unsigned frame_len(input int unsigned width);
        return 3 + width / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts after last_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     last_i,
    output logic [IW-1:0]     grant_o,
    output logic              any_o
);

    logic [IW-1:0] w_idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = IW'((int'(last_i) + i) % NUM_CH);
            if (!any_o && req_i[w_idx]) begin
                any_o   = 1'b1;
                grant_o = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chg_frame_tx.sv
// ============================================================================
// Module      : chg_frame_tx
// Description : Arbitrates change flags, snapshots the winner's register and
//               sends it as a checksummed byte frame, then acks the channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chg_frame_tx
    import chg_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       chg,
    input  logic [NUM_CH*WIDTH-1:0] register,
    output logic [NUM_CH-1:0]       ack,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] C_LAST_BYTE = CW'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]  snap_q,  snap_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [7:0]        csum_q,  csum_d;
    logic [7:0]        data_q,  data_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] ack_q,   ack_d;

    logic [IW-1:0]     w_gnt;
    logic              w_any;
    logic              w_hs;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_arb (
        .req_i   (chg),
        .last_i  (grant_q),
        .grant_o (w_gnt),
        .any_o   (w_any)
    );

    // Byte k of the snapshot, most significant byte first.
    function automatic logic [7:0] sel_byte(input logic [WIDTH-1:0] v, input logic [CW-1:0] k);
        return 8'(v >> ((NBYTES - 1 - int'(k)) * 8));
    endfunction

    assign w_hs = valid_q && m_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    grant_d = w_gnt;
                    snap_d  = WIDTH'(register >> (int'(w_gnt) * WIDTH));
                    cnt_d   = '0;
                    csum_d  = '0;
                    data_d  = SYNC_BYTE;
                    valid_d = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    data_d  = 8'(grant_q);
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (w_hs) begin
                    csum_d  = csum_q + data_q;
                    data_d  = sel_byte(snap_q, '0);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    csum_d = csum_q + data_q;
                    if (cnt_q == C_LAST_BYTE) begin
                        data_d  = csum_q + data_q;
                        state_d = ST_CSUM;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = sel_byte(snap_q, cnt_q + CW'(1));
                    end
                end
            end
            ST_CSUM: begin
                if (w_hs) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    ack_d   = NUM_CH'(1) << grant_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= IW'(NUM_CH - 1);
            snap_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire
